restoring_div_param: RTL
========================

Name: restoring_div_param

Overview:
Parametrised multi-cycle restoring integer divider for the execute stage. It is the successor to the fixed 32-bit single-bit-per-cycle divider. WIDTH is configurable, and BPC sets how many quotient bits are resolved per clock. The block captures operands and signs at start, reports divide-by-zero explicitly, and holds its result until the pipeline drops start_i.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 8
BPC, 1, quotient bits per cycle; legal values 1, 2, 4; WIDTH % BPC == 0 (elaboration-time check)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
signed_div_i  in  1  1 = signed (two's complement) divide, 0 = unsigned
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  request; level held by pipeline until result consumed
annul_i  in  1  abort the in-flight divide (exception/flush)
result_o  out  2*WIDTH  {remainder, quotient}
ready_o  out  1  result valid
div_by_zero_o  out  1  qualifies result_o when ready_o=1
busy_o  out  1  1 in any state other than FREE

Behaviour:
- Reset (rst=0, async): state=FREE; result_o=0, ready_o=0, div_by_zero_o=0, busy_o=0. All internal registers cleared. Reset mid-operation discards the divide.
- States: FREE, DIVZ, ON, FIX, END. Encodings come from the package.
- FREE:
  - Accept when start_i=1 and annul_i=0.
  - On accept, register signed_div_i, sign1=signed&op1[W-1], sign2=signed&op2[W-1], |op1|, |op2|.
  - divisor==0 -> DIVZ; otherwise -> ON with cnt=0.
  - When not accepting, drive result_o=0, ready_o=0.
- ON:
  - Each cycle performs BPC chained restoring steps on a (2W+1)-bit partial-remainder/quotient register.
  - Per step: trial = {1'b0, rem_hi} - {1'b0, divisor}. If borrow, shift left with 0; otherwise rem_hi=trial, shift with 1.
  - ITERS = WIDTH/BPC cycles, then -> FIX.
- FIX (one cycle):
  - Quotient is negated if sign1^sign2.
  - Remainder is negated if sign1.
  - Uses only registered signs, never live inputs.
  - Then -> END.
- DIVZ (one cycle): quotient = all ones, remainder = original opdata1 (unmodified); set dbz flag. -> END.
- END:
  - ready_o=1, result_o valid, div_by_zero_o=dbz.
  - Held stable while start_i=1.
  - When start_i=0: -> FREE and clear result_o, ready_o, div_by_zero_o in the same edge.
- Annul: annul_i=1 in DIVZ/ON/FIX -> FREE next edge; ready_o never asserts for that request. annul_i is ignored in END.
- Latency: accept edge = T0; ready_o rises at edge T0+ITERS+2. Examples: 34 cycles (W=32, BPC=1), 18 (BPC=2), 10 (BPC=4). Divide-by-zero: T0+2.
- Overflow: signed MIN / -1 yields quotient = MIN (wraps), remainder = 0, div_by_zero_o=0. No trap.
- Widths: magnitude conversion is ~x+1 in WIDTH bits, so |MIN| = 2^(W-1) as unsigned, which is correct.
- A new start is only accepted from FREE, so back-to-back requests need one FREE cycle.

Decomposition:
- Package div_pkg: state encodings (DIV_FREE, DIV_BYZERO, DIV_ON, DIV_FIX, DIV_END), DIV_START/DIV_STOP, READY/NOT_READY constants, and a function returning ITERS.
- Sub-module div_step: combinational single restoring step (inputs rem_hi, low bits, divisor; outputs next register). Instantiated BPC times in a generate chain.

Test Plan:
- W=32, BPC=1, unsigned 100/7 -> result_o={32'd2, 32'd14}, ready_o rises exactly 34 cycles after accept, held while start_i=1.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
- Divisor 0, dividend 0x12345678 -> ready at T0+2, div_by_zero_o=1, result={0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero_o=0. Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at cycle 10 of ON -> FREE next edge, ready_o stays 0. Then async rst low mid-ON -> all outputs 0 immediately.
- BPC=4, W=32: 1000 random signed and unsigned pairs checked against the reference model; latency 10. Also drop start_i in END -> FREE next edge with result_o=0.

Source files
------------

// File: rtl/restoring_div_param_pkg.sv
// Shared types and constants for the parametrised
// restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    DIV_FREE   = 3'd0,
    DIV_BYZERO = 3'd1,
    DIV_ON     = 3'd2,
    DIV_FIX    = 3'd3,
    DIV_END    = 3'd4
  } div_state_e;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;
  localparam logic READY     = 1'b1;
  localparam logic NOT_READY = 1'b0;

  // Clock cycles spent in DIV_ON.
  function automatic int div_iters(
    input int width,
    input int bpc
  );
    return width / bpc;
  endfunction

endpackage

// File: rtl/restoring_div_param_if.sv
// Request/response bundle between the execute
// stage and the divider.
interface restoring_div_param_if #(
  parameter int WIDTH = 32
) ();

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               div_by_zero_o;
  logic               busy_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o,
    input  div_by_zero_o,
    input  busy_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o,
    output div_by_zero_o,
    output busy_o
  );

endinterface

// File: rtl/restoring_div_param_step.sv
// One combinational restoring step: compare, restore
// or subtract, and shift in one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_hi_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] next_o
);

  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             msb_unused;

  // rem_hi carries one extra bit so a partial
  // remainder close to 2^WIDTH still compares right.
  assign trial  = {1'b0, rem_hi_i}
                - {2'b00, divisor_i};
  assign borrow = trial[WIDTH+1];

  // After a successful subtract the result is below
  // the divisor, so its top bit is always zero.
  assign msb_unused = trial[WIDTH];

  assign next_o = borrow
    ? {rem_hi_i[WIDTH-1:0], low_i, 1'b0}
    : {trial[WIDTH-1:0], low_i, 1'b1};

endmodule

// File: rtl/restoring_div_param.sv
// Multi-cycle restoring divider, BPC quotient bits
// per clock, explicit divide-by-zero reporting.
module restoring_div_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic clk,
  input  logic rst,
  restoring_div_param_if.slave bus
);

  localparam int ITERS = div_iters(WIDTH, BPC);
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(ITERS - 1);

  if ((BPC != 1 && BPC != 2 && BPC != 4) ||
      (WIDTH % BPC) != 0 ||
      (WIDTH % 2) != 0 ||
      WIDTH < 8) begin : g_bad_cfg
    $error("restoring_div_param: bad WIDTH/BPC");
  end

  function automatic logic [WIDTH-1:0] mag(
    input logic             neg,
    input logic [WIDTH-1:0] v
  );
    return neg ? ~v + WIDTH'(1) : v;
  endfunction

  div_state_e         state;
  logic [2*WIDTH:0]   r_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   op1_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               dbz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] res_q;

  logic               s1;
  logic               s2;
  logic               accept;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               pad_unused;
  logic [2*WIDTH:0]   step_out;

  assign s1 = bus.signed_div_i
            & bus.opdata1_i[WIDTH-1];
  assign s2 = bus.signed_div_i
            & bus.opdata2_i[WIDTH-1];
  assign accept = (bus.start_i == DIV_START)
                & ~bus.annul_i;

  // Quotient fills the low bits; the bit between
  // the halves is the spent pre-shift slot.
  assign quot       = r_q[WIDTH-1:0];
  assign rem        = r_q[2*WIDTH:WIDTH+1];
  assign pad_unused = r_q[WIDTH];

  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [2*WIDTH:0] cur;
    logic [2*WIDTH:0] nxt;
    if (i == 0) begin : g_first
      assign cur = r_q;
    end else begin : g_next
      assign cur = g_step[i-1].nxt;
    end
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_hi_i  (cur[2*WIDTH:WIDTH]),
      .low_i     (cur[WIDTH-1:0]),
      .divisor_i (dvs_q),
      .next_o    (nxt)
    );
  end

  assign step_out = g_step[BPC-1].nxt;

  // Control FSM, datapath registers and
  // registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= DIV_FREE;
      r_q               <= '0;
      dvs_q             <= '0;
      op1_q             <= '0;
      sign1_q           <= 1'b0;
      sign2_q           <= 1'b0;
      dbz_q             <= 1'b0;
      cnt_q             <= '0;
      res_q             <= '0;
      bus.result_o      <= '0;
      bus.ready_o       <= NOT_READY;
      bus.div_by_zero_o <= 1'b0;
      bus.busy_o        <= 1'b0;
    end else begin
      unique case (state)
        DIV_FREE: begin
          bus.result_o      <= '0;
          bus.ready_o       <= NOT_READY;
          bus.div_by_zero_o <= 1'b0;
          if (accept) begin
            sign1_q    <= s1;
            sign2_q    <= s2;
            op1_q      <= bus.opdata1_i;
            dvs_q      <= mag(s2, bus.opdata2_i);
            r_q        <= {{WIDTH{1'b0}},
                           mag(s1, bus.opdata1_i),
                           1'b0};
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
            bus.busy_o <= 1'b1;
            if (bus.opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          if (bus.annul_i) begin
            state      <= DIV_FREE;
            bus.busy_o <= 1'b0;
          end else begin
            res_q <= {op1_q, {WIDTH{1'b1}}};
            dbz_q <= 1'b1;
            state <= DIV_END;
          end
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state      <= DIV_FREE;
            bus.busy_o <= 1'b0;
          end else begin
            r_q   <= step_out;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state <= DIV_FIX;
            end
          end
        end
        DIV_FIX: begin
          if (bus.annul_i) begin
            state      <= DIV_FREE;
            bus.busy_o <= 1'b0;
          end else begin
            res_q <= {
              sign1_q ? ~rem + WIDTH'(1) : rem,
              (sign1_q ^ sign2_q)
                ? ~quot + WIDTH'(1) : quot
            };
            state <= DIV_END;
          end
        end
        DIV_END: begin
          if (bus.start_i == DIV_STOP) begin
            state             <= DIV_FREE;
            bus.result_o      <= '0;
            bus.ready_o       <= NOT_READY;
            bus.div_by_zero_o <= 1'b0;
            bus.busy_o        <= 1'b0;
          end else begin
            bus.result_o      <= res_q;
            bus.ready_o       <= READY;
            bus.div_by_zero_o <= dbz_q;
          end
        end
        default: begin
          state      <= DIV_FREE;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
